dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder_rr_arbiter.sv | 32 +++
 rtl/dmem_responder.sv | 110 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 256;
  localparam int XACT_W        = 16;

  // Low bit of core idx's field inside a flattened per-core bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-side data-memory bus shared by all cores
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W
) ();

  logic [NUM_CORES-1:0]        req_valid;
  logic [NUM_CORES-1:0]        req_we;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES*DATA_W-1:0] req_wdata;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        resp_valid;
  logic [DATA_W-1:0]           resp_rdata;
  logic                        busy;
  logic [XACT_W-1:0]           xact_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  gnt, resp_valid, resp_rdata, busy, xact_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output gnt, resp_valid, resp_rdata, busy, xact_count
  );

endinterface

// File: rtl/dmem_responder_rr_arbiter.sv
// rtl/dmem_responder_rr_arbiter.sv - combinational round-robin pick starting after last grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    // k = N wraps back to last itself, so a lone requester always wins.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - arbitrated single-port data memory shared by several cores
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = $clog2(NUM_CORES);

  state_t               state, state_n;
  logic [CW-1:0]        last_grant;
  logic [CW-1:0]        win_q;
  logic                 we_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [NUM_CORES-1:0] win_oh;

  logic [NUM_CORES-1:0] arb_grant;
  logic [CW-1:0]        arb_idx;
  logic                 arb_any;

  logic [DATA_W-1:0]    mem [DEPTH];

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req       (bus.req_valid),
    .last      (last_grant),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arb_any) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    win_oh        = '0;
    win_oh[win_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gnt        <= '0;
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      bus.busy       <= 1'b0;
      bus.xact_count <= '0;
      last_grant     <= CW'(NUM_CORES - 1);
      win_q          <= '0;
      we_q           <= 1'b0;
      idx_q          <= '0;
      wdata_q        <= '0;
    end else begin
      bus.gnt        <= '0;
      bus.resp_valid <= '0;
      bus.busy       <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (arb_any) begin
            win_q   <= arb_idx;
            we_q    <= bus.req_we[arb_idx];
            // Upper address bits are dropped: the RAM aliases modulo DEPTH.
            idx_q   <= bus.req_addr[slice_lo(int'(arb_idx), ADDR_W) +: IDX_W];
            wdata_q <= bus.req_wdata[slice_lo(int'(arb_idx), DATA_W) +: DATA_W];
            bus.gnt <= arb_grant;
          end
        end
        ACCESS: begin
          bus.resp_rdata <= we_q ? wdata_q : mem[idx_q];
          bus.resp_valid <= win_oh;
        end
        RESP: begin
          last_grant     <= win_q;
          bus.xact_count <= bus.xact_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write only commits from ACCESS, so a reset during ACCESS leaves RAM untouched.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
